// File: rtl/dii_packet_arbiter_pkg.sv
// Shared DII link types and helpers for the packet arbiter.
// The flit layout matches the DII link: valid, last, 16-bit payload.
package dii_packet_arbiter_pkg;

    localparam int DII_DATA_W = 16;

    typedef struct packed {
        logic                  valid;
        logic                  last;
        logic [DII_DATA_W-1:0] data;
    } dii_flit;

    // Port index reached by stepping 'offset' positions past 'base', wrapping at 'ports'.
    function automatic int wrap_idx(input int base, input int offset, input int ports);
        return (base + offset) % ports;
    endfunction

endpackage

// File: rtl/dii_packet_arbiter_rr_select.sv
// Round-robin find-first: picks the first requesting port after last_grant, wrapping.
// Purely combinational; last_grant itself is the lowest priority.
module dii_rr_select
    import dii_packet_arbiter_pkg::*;
#(
    parameter int PORTS = 4,
    parameter int PTR_W = $clog2(PORTS)
) (
    input  logic [PORTS-1:0] req,
    input  logic [PTR_W-1:0] last_grant,
    output logic [PTR_W-1:0] sel,
    output logic             any
);

    always_comb begin
        sel = '0;
        any = 1'b0;
        for (int off = 1; off <= PORTS; off++) begin
            if (!any && req[wrap_idx(int'(last_grant), off, PORTS)]) begin
                any = 1'b1;
                sel = PTR_W'(wrap_idx(int'(last_grant), off, PORTS));
            end
        end
    end

endmodule

// File: rtl/dii_packet_arbiter.sv
// Packet-granular round-robin merge of several DII flit streams onto one link.
// A granted port keeps the link until its last flit is accepted, so packets never interleave.
module dii_packet_arbiter
    import dii_packet_arbiter_pkg::*;
#(
    parameter  int PORTS = 4,
    localparam int PTR_W = $clog2(PORTS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  dii_flit [PORTS-1:0]   flit_in,
    output logic    [PORTS-1:0]   flit_in_ready,
    output dii_flit               flit_out,
    input  logic                  flit_out_ready,
    output logic    [PTR_W-1:0]   grant,
    output logic                  locked
);

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_e;

    state_e           state, state_nxt;
    logic [PTR_W-1:0] cur_grant, cur_grant_nxt;
    logic [PTR_W-1:0] last_grant, last_grant_nxt;
    logic [PTR_W-1:0] rr_sel, sel;
    logic [PORTS-1:0] req;
    logic             rr_any, have_sel, xfer;

    always_comb begin
        req = '0;
        for (int i = 0; i < PORTS; i++) begin
            req[i] = flit_in[i].valid;
        end
    end

    dii_rr_select #(
        .PORTS (PORTS),
        .PTR_W (PTR_W)
    ) u_rr_select (
        .req        (req),
        .last_grant (last_grant),
        .sel        (rr_sel),
        .any        (rr_any)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cur_grant  <= '0;
            last_grant <= PTR_W'(PORTS - 1);
        end else begin
            state      <= state_nxt;
            cur_grant  <= cur_grant_nxt;
            last_grant <= last_grant_nxt;
        end
    end

    // Selection never depends on flit_out_ready; only the ready fan-out and the
    // transfer decision do.
    always_comb begin
        state_nxt      = state;
        cur_grant_nxt  = cur_grant;
        last_grant_nxt = last_grant;
        sel            = rr_sel;
        have_sel       = rr_any;
        flit_out       = '0;
        flit_in_ready  = '0;

        if (state == LOCKED) begin
            sel      = cur_grant;
            have_sel = 1'b1;
        end
        if (rst) begin
            have_sel = 1'b0;
        end

        if (have_sel) begin
            flit_out           = flit_in[sel];
            flit_in_ready[sel] = flit_out_ready;
        end

        xfer = flit_out.valid && flit_out_ready;

        case (state)
            IDLE: begin
                if (have_sel) begin
                    if (xfer && flit_out.last) begin
                        last_grant_nxt = sel;
                    end else begin
                        // Stalled first flit or accepted non-last flit both lock the grant.
                        state_nxt     = LOCKED;
                        cur_grant_nxt = sel;
                    end
                end
            end
            LOCKED: begin
                if (xfer && flit_out.last) begin
                    state_nxt      = IDLE;
                    last_grant_nxt = cur_grant;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign grant  = sel;
    assign locked = (state == LOCKED);

endmodule

// File: tb/tb_dii_packet_arbiter.sv
// Directed bench for dii_packet_arbiter: per-port flit queues drive the inputs,
// a negedge monitor pops the expected-transfer scoreboard on every output handshake.
module tb_dii_packet_arbiter;
    import dii_packet_arbiter_pkg::*;

    localparam int PORTS = 4;

    logic                clk = 1'b0;
    logic                rst;
    dii_flit [PORTS-1:0] flit_in;
    logic    [PORTS-1:0] flit_in_ready;
    dii_flit             flit_out;
    logic                flit_out_ready;
    logic    [1:0]       grant;
    logic                locked;

    dii_packet_arbiter #(.PORTS(PORTS)) dut (
        .clk            (clk),
        .rst            (rst),
        .flit_in        (flit_in),
        .flit_in_ready  (flit_in_ready),
        .flit_out       (flit_out),
        .flit_out_ready (flit_out_ready),
        .grant          (grant),
        .locked         (locked)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]  port;
        logic [15:0] data;
        logic        last;
    } exp_t;

    exp_t        sb[$];
    exp_t        e;
    logic [16:0] pq[PORTS][$];
    bit          hold[PORTS];
    bit          acc[PORTS];
    int          tests = 0;
    int          fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        for (int i = 0; i < PORTS; i++) begin
            acc[i] = flit_in[i].valid && flit_in_ready[i];
        end
        if (!rst && flit_out.valid && flit_out_ready) begin
            tests++;
            if (sb.size() == 0) begin
                fails++;
                $display("FAIL unexpected_xfer: got port %0d data %0h, expected no transfer",
                         grant, flit_out.data);
            end else begin
                e = sb.pop_front();
                if (grant !== e.port || flit_out.data !== e.data || flit_out.last !== e.last) begin
                    fails++;
                    $display("FAIL xfer: got port %0d data %0h last %0b, expected port %0d data %0h last %0b",
                             grant, flit_out.data, flit_out.last, e.port, e.data, e.last);
                end
            end
        end
    end

    task automatic send(input int p, input logic [15:0] d, input logic l);
        pq[p].push_back({l, d});
    endtask

    task automatic expect_xfer(input int p, input logic [15:0] d, input logic l);
        exp_t x;
        x.port = 2'(p);
        x.data = d;
        x.last = l;
        sb.push_back(x);
    endtask

    task automatic apply();
        for (int i = 0; i < PORTS; i++) begin
            if (pq[i].size() > 0 && !hold[i]) flit_in[i] = {1'b1, pq[i][0]};
            else                              flit_in[i] = '0;
        end
    endtask

    task automatic half1();
        apply();
        @(negedge clk);
    endtask

    task automatic half2();
        @(posedge clk);
        #1;
        for (int i = 0; i < PORTS; i++) begin
            if (acc[i]) begin
                if (pq[i].size() > 0) void'(pq[i].pop_front());
                acc[i] = 1'b0;
            end
        end
    endtask

    task automatic step();
        half1();
        half2();
    endtask

    initial begin
        rst            = 1'b1;
        flit_out_ready = 1'b1;
        flit_in        = '0;
        for (int i = 0; i < PORTS; i++) begin
            hold[i] = 1'b0;
            acc[i]  = 1'b0;
        end

        // Reset: a pending request must stay invisible while rst is high.
        send(0, 16'h0A01, 1'b1);
        expect_xfer(0, 16'h0A01, 1'b1);
        for (int c = 0; c < 2; c++) begin
            half1();
            chk("rst_valid", 32'(flit_out.valid), 32'h0);
            chk("rst_ready", 32'(flit_in_ready), 32'h0);
            chk("rst_locked", 32'(locked), 32'h0);
            half2();
        end
        rst = 1'b0;
        half1();
        chk("first_grant", 32'(grant), 32'h0);
        chk("first_ready", 32'(flit_in_ready), 32'h1);
        half2();

        // Single-flit packet from port 2.
        send(2, 16'h2001, 1'b1);
        expect_xfer(2, 16'h2001, 1'b1);
        half1();
        chk("single_grant", 32'(grant), 32'h2);
        chk("single_locked", 32'(locked), 32'h0);
        chk("single_ready", 32'(flit_in_ready), 32'h4);
        half2();
        half1();
        chk("single_after_locked", 32'(locked), 32'h0);
        chk("single_after_valid", 32'(flit_out.valid), 32'h0);
        half2();

        // Round robin with all ports requesting; last winner was port 2, so port 3 leads.
        for (int r = 0; r < 2; r++)
            for (int p = 0; p < PORTS; p++)
                send(p, 16'h3000 | 16'(r << 4) | 16'(p), 1'b1);
        for (int k = 0; k < 8; k++)
            expect_xfer((3 + k) % PORTS, 16'h3000 | 16'((k / 4) << 4) | 16'((3 + k) % PORTS), 1'b1);
        for (int k = 0; k < 8; k++) begin
            half1();
            chk("rr_locked", 32'(locked), 32'h0);
            half2();
        end

        // Packet lock: park the pointer on port 0, then port 1 sends 3 flits while port 0 waits.
        send(0, 16'h0B00, 1'b1);
        expect_xfer(0, 16'h0B00, 1'b1);
        step();
        send(1, 16'h1C01, 1'b0);
        send(1, 16'h1C02, 1'b0);
        send(1, 16'h1C03, 1'b1);
        send(0, 16'h0C00, 1'b1);
        expect_xfer(1, 16'h1C01, 1'b0);
        expect_xfer(1, 16'h1C02, 1'b0);
        expect_xfer(1, 16'h1C03, 1'b1);
        expect_xfer(0, 16'h0C00, 1'b1);
        half1();
        chk("lock_c1_grant", 32'(grant), 32'h1);
        chk("lock_c1_locked", 32'(locked), 32'h0);
        chk("lock_c1_ready0", 32'(flit_in_ready[0]), 32'h0);
        half2();
        for (int c = 0; c < 2; c++) begin
            half1();
            chk("lock_grant", 32'(grant), 32'h1);
            chk("lock_locked", 32'(locked), 32'h1);
            chk("lock_ready0", 32'(flit_in_ready[0]), 32'h0);
            half2();
        end
        half1();
        chk("lock_next_grant", 32'(grant), 32'h0);
        chk("lock_next_locked", 32'(locked), 32'h0);
        half2();

        // Backpressure on a first flit: port 3 holds the grant, port 0 joins later.
        flit_out_ready = 1'b0;
        send(3, 16'h3D00, 1'b1);
        expect_xfer(3, 16'h3D00, 1'b1);
        expect_xfer(0, 16'h0D00, 1'b1);
        half1();
        chk("bp_c1_grant", 32'(grant), 32'h3);
        chk("bp_c1_locked", 32'(locked), 32'h0);
        chk("bp_c1_valid", 32'(flit_out.valid), 32'h1);
        half2();
        send(0, 16'h0D00, 1'b1);
        for (int c = 0; c < 4; c++) begin
            half1();
            chk("bp_grant", 32'(grant), 32'h3);
            chk("bp_locked", 32'(locked), 32'h1);
            chk("bp_data", 32'(flit_out.data), 32'h3D00);
            chk("bp_ready", 32'(flit_in_ready), 32'h0);
            half2();
        end
        flit_out_ready = 1'b1;
        half1();
        chk("bp_release_ready", 32'(flit_in_ready), 32'h8);
        half2();
        half1();
        chk("bp_after_grant", 32'(grant), 32'h0);
        chk("bp_after_locked", 32'(locked), 32'h0);
        half2();

        // Mid-packet bubble: port 1 pauses, port 2 must not sneak in.
        send(1, 16'h1E01, 1'b0);
        send(1, 16'h1E02, 1'b0);
        send(1, 16'h1E03, 1'b1);
        send(2, 16'h2E00, 1'b1);
        expect_xfer(1, 16'h1E01, 1'b0);
        expect_xfer(1, 16'h1E02, 1'b0);
        expect_xfer(1, 16'h1E03, 1'b1);
        expect_xfer(2, 16'h2E00, 1'b1);
        half1();
        chk("bub_c1_grant", 32'(grant), 32'h1);
        half2();
        hold[1] = 1'b1;
        for (int c = 0; c < 2; c++) begin
            half1();
            chk("bub_valid", 32'(flit_out.valid), 32'h0);
            chk("bub_ready2", 32'(flit_in_ready[2]), 32'h0);
            chk("bub_locked", 32'(locked), 32'h1);
            chk("bub_grant", 32'(grant), 32'h1);
            half2();
        end
        hold[1] = 1'b0;
        half1();
        chk("bub_resume_data", 32'(flit_out.data), 32'h1E02);
        half2();
        half1();
        chk("bub_last_locked", 32'(locked), 32'h1);
        half2();
        half1();
        chk("bub_next_grant", 32'(grant), 32'h2);
        chk("bub_next_locked", 32'(locked), 32'h0);
        half2();

        // Reset mid-packet on port 2; port 0 must win first afterwards.
        send(2, 16'h2F01, 1'b0);
        send(2, 16'h2F02, 1'b0);
        send(2, 16'h2F03, 1'b1);
        expect_xfer(2, 16'h2F01, 1'b0);
        half1();
        chk("rmp_grant", 32'(grant), 32'h2);
        half2();
        chk("rmp_locked_before", 32'(locked), 32'h1);
        rst = 1'b1;
        half1();
        chk("rmp_rst_ready", 32'(flit_in_ready), 32'h0);
        chk("rmp_rst_valid", 32'(flit_out.valid), 32'h0);
        half2();
        half1();
        chk("rmp_locked", 32'(locked), 32'h0);
        chk("rmp_ready", 32'(flit_in_ready), 32'h0);
        half2();
        pq[2].delete();
        for (int p = 0; p < PORTS; p++) begin
            send(p, 16'h4000 | 16'(p), 1'b1);
            expect_xfer(p, 16'h4000 | 16'(p), 1'b1);
        end
        rst = 1'b0;
        half1();
        chk("rmp_first_grant", 32'(grant), 32'h0);
        half2();
        for (int c = 0; c < 3; c++) step();

        step();
        step();
        chk("sb_drained", 32'(sb.size()), 32'h0);
        for (int p = 0; p < PORTS; p++)
            chk("queue_drained", 32'(pq[p].size()), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
